aes_inv_sub_bytes_stage: RTL
============================

Name: aes_inv_sub_bytes_stage

Overview:
Decryption-side counterpart of the encryption SubBytes stage. Applies the AES inverse S-box to a 128-bit state in the AES decryption datapath. It uses LANES byte lookups per cycle and iterates over the 16 bytes in 16/LANES beats. The round key, round index and last-round flag pass through alongside the state, with a valid/ready handshake on both sides.

Parameters:
LANES, 4, byte lookups per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error.
BEATS, 16/LANES, localparam, cycles spent in BUSY per block.

Ports:
clock  in  1  single clock; all state changes on the rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  input block valid.
in_ready  out  1  stage can accept a block.
in_state  in  128  ciphertext-side state; byte i = in_state[127-8i -: 8], so byte 0 is the MSB.
in_key  in  128  round key, passed through unmodified.
in_round  in  4  round index, passed through.
in_last  in  1  final-round flag, passed through.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
out_state  out  128  inverse-substituted state, same byte order as in_state.
out_key  out  128  captured in_key.
out_round  out  4  captured in_round.
out_last  out  1  captured in_last.

Behaviour:
- Interface as decided: one clock `clock`; `reset` is asynchronous and active-high.
- Reset values: FSM=IDLE, beat_cnt=0, out_valid=0, out_state=0, out_key=0, out_round=0, out_last=0.
- FSM IDLE:
  - in_ready=1.
  - On in_valid && in_ready: capture state, key, round and last into work registers; beat_cnt=0; go to BUSY.
- FSM BUSY:
  - in_ready=0.
  - Each cycle, bytes [beat_cnt*LANES, beat_cnt*LANES+LANES-1] of the work register are replaced by InvSbox(byte); beat_cnt increments.
  - When beat_cnt==BEATS-1: the final lanes are written directly into out_state; out_valid=1; go to DONE.
- FSM DONE:
  - out_valid=1. All out_* held stable until out_ready=1.
  - If out_ready=1 and in_valid=1 in the same cycle: in_ready=1 (combinational from out_ready); the result is consumed and the new block is captured in that cycle; go to BUSY.
  - If out_ready=1 and in_valid=0: out_valid clears; go to IDLE.
- Latency: out_valid rises exactly BEATS cycles after the accepting edge.
- Throughput: one block per BEATS+1 cycles under continuous in_valid and out_ready. LANES=16 gives BEATS=1.
- in_valid while BUSY, or while DONE with out_ready=0: not accepted; the upstream block must be held.
- Data outputs retain their last values after out_valid drops; they are not zeroed.
- reset asserted mid-BUSY or mid-DONE: the block is discarded immediately (asynchronous) and all outputs take reset values.
- The lookup table is constant; the table must not be rewritten per clock.

Optional Feature:
SBOX_DIR_SEL_EN:
- Defined: adds input port in_encrypt (1 bit), captured with the block. 1 selects the forward S-box and 0 the inverse S-box for every lane of that block. Adds output out_encrypt, which echoes the captured value. Both tables are instantiated per lane.
- Undefined: no extra ports; inverse table only.

Decomposition:
- Shared package aes_pkg:
  - 256-entry INV_SBOX constant and SBOX constant (SBOX also used by the encryption stage);
  - byte/word/state typedefs (byte_t, state_t as 16 x byte_t);
  - AES_NB=4 and AES_STATE_BYTES=16 constants.
- Sub-module aes_inv_sbox_lane: one combinational byte lookup, instantiated LANES times. It takes a direction select only when SBOX_DIR_SEL_EN is defined.

Test Plan:
- LANES=4, in_state all 0x63, out_ready=1 -> out_valid exactly 4 cycles after accept; out_state = 128'h0.
- in_state = 128'h0, key = 128'h0123...EF, round=9, last=1 -> out_state all 0x52; out_key/out_round/out_last echo the inputs.
- in_state bytes 0x7C, 0x16, 0xED, then 0x00 x13 -> bytes 0x01, 0xFF, 0x53, then 0x52 x13.
- out_ready held 0 for 5 cycles after out_valid, with in_valid held high and a second block waiting:
  - outputs stable and in_ready=0 throughout;
  - on out_ready=1, second block accepted the same cycle;
  - its result appears 4 cycles later.
- Assert reset during BUSY beat 2 -> out_valid=0 and all outputs zero immediately; next block after release is processed correctly.
- Build with LANES=1 and LANES=16 -> latency 16 and 1 cycles respectively; the same vectors give identical results.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: byte/state types, forward and inverse S-box tables.
// Tables are stored with entry 0 at the MSB end, so entry x lives at index ~x.
package aes_pkg;

  localparam int AES_NB          = 4;
  localparam int AES_STATE_BYTES = 16;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] word_t;
  // Byte i of the state sits at index 15-i so byte 0 is the MSB of the 128-bit word
  typedef byte_t [AES_STATE_BYTES-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } sub_fsm_e;

  localparam byte_t [255:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam byte_t [255:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic byte_t sbox_fwd(input byte_t b);
    return SBOX[~b];
  endfunction

  function automatic byte_t sbox_inv(input byte_t b);
    return INV_SBOX[~b];
  endfunction

endpackage

// File: rtl/aes_inv_sbox_lane.sv
// One combinational byte lookup lane; SBOX_DIR_SEL_EN adds a forward/inverse select.
module aes_inv_sbox_lane
  import aes_pkg::*;
(
  input  byte_t in_byte,
`ifdef SBOX_DIR_SEL_EN
  input  logic  encrypt,
`endif
  output byte_t out_byte
);

`ifdef SBOX_DIR_SEL_EN
  assign out_byte = encrypt ? sbox_fwd(in_byte) : sbox_inv(in_byte);
`else
  assign out_byte = sbox_inv(in_byte);
`endif

endmodule

// File: rtl/aes_inv_sub_bytes_stage.sv
// Iterative AES InvSubBytes stage: LANES lookups per cycle, 16/LANES beats per block.
// Optional macro SBOX_DIR_SEL_EN adds a per-block forward/inverse direction select.
module aes_inv_sub_bytes_stage
  import aes_pkg::*;
#(
  parameter int LANES = 4
)
(
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic [127:0] in_key,
  input  logic [3:0]   in_round,
  input  logic         in_last,
`ifdef SBOX_DIR_SEL_EN
  input  logic         in_encrypt,
  output logic         out_encrypt,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic [127:0] out_key,
  output logic [3:0]   out_round,
  output logic         out_last
);

  localparam int BEATS = AES_STATE_BYTES / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("aes_inv_sub_bytes_stage: LANES must be 1, 2, 4, 8 or 16");
  end

  sub_fsm_e           fsm;
  logic [CNT_W-1:0]   beat_cnt;
  state_t             work;
  state_t             work_next;
  logic [127:0]       key_r;
  logic [3:0]         round_r;
  logic               last_r;
  logic [3:0]         lane_base;
  logic               accept;
  byte_t              lane_out [LANES];
`ifdef SBOX_DIR_SEL_EN
  logic               encrypt_r;
`endif

  // A finished block may be swapped for a new one in the same cycle it is consumed
  assign in_ready  = (fsm == ST_IDLE) || ((fsm == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign lane_base = 4'(int'(beat_cnt) * LANES);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [3:0] byte_idx;
    assign byte_idx = lane_base + 4'(g);

    aes_inv_sbox_lane u_lane (
      .in_byte  (work[~byte_idx]),
`ifdef SBOX_DIR_SEL_EN
      .encrypt  (encrypt_r),
`endif
      .out_byte (lane_out[g])
    );
  end

  always_comb begin
    work_next = work;
    for (int l = 0; l < LANES; l++) begin
      work_next[~(lane_base + 4'(l))] = lane_out[l];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm       <= ST_IDLE;
      beat_cnt  <= '0;
      work      <= '0;
      key_r     <= '0;
      round_r   <= '0;
      last_r    <= 1'b0;
      out_valid <= 1'b0;
      out_state <= '0;
      out_key   <= '0;
      out_round <= '0;
      out_last  <= 1'b0;
`ifdef SBOX_DIR_SEL_EN
      encrypt_r   <= 1'b0;
      out_encrypt <= 1'b0;
`endif
    end else begin
      unique case (fsm)
        ST_IDLE: begin
          if (accept) fsm <= ST_BUSY;
        end
        ST_BUSY: begin
          work <= work_next;
          if (beat_cnt == CNT_W'(BEATS - 1)) begin
            out_state <= work_next;
            out_key   <= key_r;
            out_round <= round_r;
            out_last  <= last_r;
`ifdef SBOX_DIR_SEL_EN
            out_encrypt <= encrypt_r;
`endif
            out_valid <= 1'b1;
            beat_cnt  <= '0;
            fsm       <= ST_DONE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            fsm       <= accept ? ST_BUSY : ST_IDLE;
          end
        end
        default: fsm <= ST_IDLE;
      endcase

      // accept is only ever true in IDLE or DONE, so it never collides with a beat update
      if (accept) begin
        work     <= in_state;
        key_r    <= in_key;
        round_r  <= in_round;
        last_r   <= in_last;
        beat_cnt <= '0;
`ifdef SBOX_DIR_SEL_EN
        encrypt_r <= in_encrypt;
`endif
      end
    end
  end

endmodule
